boot_loader: RTL and testbench
==============================

# boot_loader

Byte-stream program loader that fills instruction RAM before the CPU runs. It consumes bytes from the UART receiver and assembles little-endian 32-bit words. It writes each word to instruction memory over a single-cycle write port, holding the CPU in reset until the image is complete. It sits between the UART receiver and the instruction-memory write port and drives the CPU reset line.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0, byte address of the first written word; must be 4-aligned.
- `MAX_WORDS`, 256, largest accepted image in words.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `imem_we` out 1: instruction-memory write enable, one-cycle pulse.
- `imem_addr` out 32: byte address of the write, 4-aligned.
- `imem_wdata` out 32: word to write.
- `cpu_rst` out 1: CPU reset, high while loading or in error.
- `done` out 1: image loaded, sticky.
- `error` out 1: load failed, sticky.

## Operation
- States: `HDR`, `LOAD`, `CHK` (only with the macro defined), `DONE`, `ERR`. Reset enters `HDR`.
- `HDR`:
  - Collect 4 bytes, little-endian (first byte is bits [7:0]), into word count N (32 bits).
  - After the 4th byte:
    - N > `MAX_WORDS` → `ERR`.
    - N == 0 → `CHK` if enabled, else `DONE`.
    - Otherwise → `LOAD`.
- `LOAD`:
  - Byte index 0..3 shifts the byte into `imem_wdata` bits [8i+7:8i].
  - On the 4th byte, issue a write at `BASE_ADDR + 4*k`, where k is the word index 0..N-1.
  - After write N-1 → `CHK` if enabled, else `DONE`.
- No backpressure. A byte arriving in any cycle, including one where `imem_we` is high, is accepted.
- `DONE`: `done`=1, `cpu_rst`=0. All further `rx_valid` is ignored.
- `ERR`: `error`=1, `cpu_rst`=1. All further `rx_valid` is ignored.
- Only `rst` leaves `DONE` or `ERR`.
- `done` and `error` are never both high.
- Address arithmetic is 32-bit. No wrap checking is needed because `MAX_WORDS` bounds k.

## Timing
- Reset values:
  - `imem_we`=0, `imem_addr`=`BASE_ADDR`, `imem_wdata`=0.
  - `cpu_rst`=1, `done`=0, `error`=0.
  - Byte, word and checksum counters are 0.
- Write latency:
  - `imem_we` rises in the cycle after the `rx_valid` carrying a word's 4th byte, for exactly one cycle.
  - `imem_addr` and `imem_wdata` are stable in that cycle.
- `imem_wdata` may change outside `imem_we` cycles. `imem_addr` updates only after a write.
- Completion without the macro: `done`=1 and `cpu_rst`=0 in the cycle after the final `imem_we` cycle, i.e. 2 cycles after the last byte's `rx_valid`.
- Completion with N=0 and no macro: `done`=1 in the cycle after the 4th header byte.
- Oversize error: `error`=1 in the cycle after the 4th header byte. No write is issued.
- Async reset mid-load:
  - Outputs return to reset values immediately.
  - A partial word is discarded.
  - Words already written stay in memory.
  - The load restarts at `HDR`.
- Back-to-back `rx_valid` on consecutive cycles is supported at full rate.

## Configuration
- Macro: `BOOT_LOADER_CHECKSUM_EN`.
- Defined:
  - An 8-bit running XOR covers every accepted byte of header and payload.
  - After the last payload word (or after the header when N=0), `CHK` accepts one more byte.
  - If that byte equals the running XOR → `DONE`, else → `ERR`.
  - `done` or `error` rises in the cycle after that byte's `rx_valid`.
- Undefined:
  - No checksum logic and no `CHK` state.
  - The image is accepted as soon as N words are written.

## Test plan
- Image N=2, words 32'h40000113 and 32'h00000413, sent as bytes 02 00 00 00 13 01 00 40 13 04 00 00 (no macro):
  - `imem_we` pulses twice: addr 0x0/data 32'h40000113, then addr 0x4/data 32'h00000413.
  - `done`=1 and `cpu_rst`=0 two cycles after the last byte.
- Header N=`MAX_WORDS`+1 (257 = 01 01 00 00):
  - `error`=1 one cycle after the 4th byte.
  - No `imem_we`; `cpu_rst` stays 1.
  - Further bytes are ignored.
- With macro, N=1, word 32'h00000093, bytes 01 00 00 00 93 00 00 00:
  - Checksum byte 0x92 → `done`=1.
  - Repeat with checksum 0x00 → `error`=1 and `cpu_rst`=1.
- N=0 header:
  - Without macro, `done` one cycle after the header, zero writes.
  - With macro, checksum byte 0x00 → `done`.
- Assert `rst` after the 6th byte of the first test:
  - Outputs reset immediately.
  - Resending the full image yields identical writes and `done`.
- `BASE_ADDR`=32'h100, N=3, bytes on consecutive cycles:
  - Writes land at 0x100, 0x104, 0x108.
  - Each write occurs exactly one cycle after its 4th byte.

Source files
------------

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
//
// Purpose:
//   Fills instruction RAM from a UART byte stream before the CPU runs. The
//   stream is a 4-byte little-endian word count N followed by N little-endian
//   32-bit words. Each assembled word is written to instruction memory through
//   a single-cycle write port at BASE_ADDR + 4*k. The CPU is held in reset
//   until the image is complete.
//
// Configuration:
//   BOOT_LOADER_CHECKSUM_EN - when defined, one extra byte follows the image.
//   It must equal the XOR of every header and payload byte, otherwise the
//   load ends in error.
//
// Parameters:
//   BASE_ADDR  - byte address of the first word (4-aligned).
//   MAX_WORDS  - largest accepted image, in words.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   rx_data     in   received byte
//   rx_valid    in   one-cycle strobe qualifying rx_data (no backpressure)
//   imem_we     out  instruction-memory write enable, one-cycle pulse
//   imem_addr   out  write byte address, advances only after a write
//   imem_wdata  out  write data
//   cpu_rst     out  CPU reset, high until the image is accepted
//   done        out  image loaded (sticky until rst)
//   error       out  load failed (sticky until rst)
//   dbg_state   out  current FSM state encoding, for debug/observation
//
// Handshake: rx_valid is a strobe with no ready; every byte presented while
// the FSM is collecting (HDR, LOAD, CHK) is consumed in that cycle, including
// cycles where imem_we is high. Bytes in DONE or ERR are dropped.
// -----------------------------------------------------------------------------
module boot_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int          MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_rst,
   output logic        done,
   output logic        error,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      HDR  = 3'd0,
      LOAD = 3'd1,
      DONE = 3'd2,
      ERR  = 3'd3
`ifdef BOOT_LOADER_CHECKSUM_EN
      ,
      CHK  = 3'd4
`endif
   } state_t;

   // Where the FSM goes once the last word (or an empty header) is taken.
`ifdef BOOT_LOADER_CHECKSUM_EN
   localparam state_t END_STATE = CHK;
`else
   localparam state_t END_STATE = DONE;
`endif

   localparam logic [31:0] MAX_WORDS_32 = 32'(MAX_WORDS);

   state_t      state_q,    state_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [31:0] count_q,    count_d;     // word count N from the header
   logic [31:0] word_idx_q, word_idx_d;  // k, index of the next word to write
   logic [31:0] wdata_q,    wdata_d;
   logic [31:0] addr_q,     addr_d;
   logic        we_q,       we_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q,     csum_d;
`endif

   logic [31:0] hdr_full;   // header value including the byte arriving now
   logic        last_word;  // the word being completed is word N-1

   assign hdr_full  = {rx_data, count_q[23:0]};
   assign last_word = (word_idx_q == (count_q - 32'd1));

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= HDR;
         byte_idx_q <= 2'd0;
         count_q    <= 32'd0;
         word_idx_q <= 32'd0;
         wdata_q    <= 32'd0;
         addr_q     <= BASE_ADDR;
         we_q       <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
         csum_q     <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         wdata_q    <= wdata_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      wdata_d    = wdata_q;
      addr_d     = addr_q;
      we_d       = 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif

      // The address is held through the write cycle and advances right after,
      // so it already points at the next word when that word's write issues.
      if (we_q) begin
         addr_d = addr_q + 32'd4;
      end

      case (state_q)
         HDR: begin
            if (rx_valid) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               count_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  if (hdr_full > MAX_WORDS_32) begin
                     state_d = ERR;
                  end else if (hdr_full == 32'd0) begin
                     state_d = END_STATE;
                  end else begin
                     state_d = LOAD;
                  end
               end
            end
         end

         LOAD: begin
            if (rx_valid) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               wdata_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  we_d       = 1'b1;
                  word_idx_d = word_idx_q + 32'd1;
                  if (last_word) begin
                     state_d = END_STATE;
                  end
               end
            end
         end

`ifdef BOOT_LOADER_CHECKSUM_EN
         CHK: begin
            if (rx_valid) begin
               state_d = (rx_data == csum_q) ? DONE : ERR;
            end
         end
`endif

         DONE: begin
            state_d = DONE;
         end

         ERR: begin
            state_d = ERR;
         end

         default: begin
            state_d = HDR;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;

   // Without the checksum the FSM enters DONE together with the final write
   // pulse; done is held off during that pulse so it rises one cycle later.
   assign done      = (state_q == DONE) && !we_q;
   assign error     = (state_q == ERR);
   assign cpu_rst   = !done;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
//
// Directed bench for boot_loader. Instance dut uses BASE_ADDR 0, dut_b uses
// BASE_ADDR 0x100. Inputs are driven on the falling edge and outputs are
// sampled on the falling edge. Writes from dut are checked against an
// expected queue of {addr, data}.
// -----------------------------------------------------------------------------
module tb_boot_loader;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut (BASE_ADDR = 0)
  logic [7:0]  rx_data  = 8'd0;
  logic        rx_valid = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  // dut_b (BASE_ADDR = 0x100)
  logic [7:0]  rx_data_b  = 8'd0;
  logic        rx_valid_b = 1'b0;
  logic        imem_we_b;
  logic [31:0] imem_addr_b;
  logic [31:0] imem_wdata_b;
  logic        cpu_rst_b;
  logic        done_b;
  logic        error_b;
  logic [2:0]  dbg_state_b;

  boot_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  boot_loader #(.BASE_ADDR(32'h100), .MAX_WORDS(256)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data_b),
    .rx_valid   (rx_valid_b),
    .imem_we    (imem_we_b),
    .imem_addr  (imem_addr_b),
    .imem_wdata (imem_wdata_b),
    .cpu_rst    (cpu_rst_b),
    .done       (done_b),
    .error      (error_b),
    .dbg_state  (dbg_state_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_err  = 0;
  int wr_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write pulse from dut must match the head of the expected queue.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_cnt++;
      check_eq("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check_eq("wr_addr_data", {imem_addr, imem_wdata}, mon_exp);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'd0;
  endtask

  task automatic drive_byte_b(input logic [7:0] b);
    rx_data_b  = b;
    rx_valid_b = 1'b1;
    @(negedge clk);
    rx_valid_b = 1'b0;
    rx_data_b  = 8'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rx_valid   = 1'b0;
    rx_valid_b = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus tables
  // ---------------------------------------------------------------------------
  logic [7:0] img1 [12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                            8'h13, 8'h01, 8'h00, 8'h40,
                            8'h13, 8'h04, 8'h00, 8'h00};
  logic [7:0] img3 [16] = '{8'h03, 8'h00, 8'h00, 8'h00,
                            8'h13, 8'h00, 8'h00, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00,
                            8'h13, 8'h81, 8'h20, 8'h00};
  logic [31:0] img3_words [3] = '{32'h00000013, 32'h00100093, 32'h00208113};

  // Sends img1 with expected writes queued and checks completion.
  task automatic run_img1(input string tag);
    int wr0;
    wr0 = wr_cnt;
    exp_q.push_back({32'h0, 32'h40000113});
    exp_q.push_back({32'h4, 32'h00000413});
    for (int i = 0; i < 12; i++) begin
      drive_byte(img1[i]);
      if (i == 7) check_eq({tag, "_we_w0"}, 64'(imem_we), 64'd1);
      if (i == 11) begin
        check_eq({tag, "_we_w1"}, 64'(imem_we), 64'd1);
        check_eq({tag, "_done_early"}, 64'(done), 64'd0);
      end
      if (i < 11) idle(i % 2);
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    drive_byte(8'h47);
`else
    idle(1);
`endif
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd0);
    check_eq({tag, "_error"}, 64'(error), 64'd0);
    check_eq({tag, "_wr_cnt"}, 64'(wr_cnt - wr0), 64'd2);
    check_eq({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int wr0;

    // Reset values
    do_reset();
    check_eq("rst_we", 64'(imem_we), 64'd0);
    check_eq("rst_addr", 64'(imem_addr), 64'h0);
    check_eq("rst_wdata", 64'(imem_wdata), 64'h0);
    check_eq("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_error", 64'(error), 64'd0);
    check_eq("rst_addr_b", 64'(imem_addr_b), 64'h100);

    // Two-word image, then trailing bytes must be ignored
    run_img1("t1");
    wr0 = wr_cnt;
    for (int i = 0; i < 4; i++) drive_byte(8'hAA);
    idle(2);
    check_eq("t1_ignored_wr", 64'(wr_cnt - wr0), 64'd0);
    check_eq("t1_done_sticky", 64'(done), 64'd1);

    // Oversize header 257
    do_reset();
    wr0 = wr_cnt;
    drive_byte(8'h01);
    drive_byte(8'h01);
    drive_byte(8'h00);
    check_eq("t2_error_early", 64'(error), 64'd0);
    drive_byte(8'h00);
    check_eq("t2_error", 64'(error), 64'd1);
    check_eq("t2_cpu_rst", 64'(cpu_rst), 64'd1);
    check_eq("t2_done", 64'(done), 64'd0);
    for (int i = 0; i < 8; i++) drive_byte(8'h13);
    idle(2);
    check_eq("t2_no_wr", 64'(wr_cnt - wr0), 64'd0);
    check_eq("t2_error_sticky", 64'(error), 64'd1);
    check_eq("t2_done_after", 64'(done), 64'd0);

    // Empty image
    do_reset();
    wr0 = wr_cnt;
    for (int i = 0; i < 4; i++) drive_byte(8'h00);
`ifdef BOOT_LOADER_CHECKSUM_EN
    check_eq("t3_done_pre_chk", 64'(done), 64'd0);
    drive_byte(8'h00);
`endif
    check_eq("t3_done", 64'(done), 64'd1);
    check_eq("t3_cpu_rst", 64'(cpu_rst), 64'd0);
    idle(2);
    check_eq("t3_no_wr", 64'(wr_cnt - wr0), 64'd0);

    // Asynchronous reset after the 6th byte, then a full reload
    do_reset();
    for (int i = 0; i < 6; i++) drive_byte(img1[i]);
    check_eq("t4_wdata_pre", 64'(imem_wdata), 64'h00000113);
    #2 rst = 1'b1;
    #1;
    check_eq("t4_we", 64'(imem_we), 64'd0);
    check_eq("t4_addr", 64'(imem_addr), 64'h0);
    check_eq("t4_wdata", 64'(imem_wdata), 64'h0);
    check_eq("t4_cpu_rst", 64'(cpu_rst), 64'd1);
    check_eq("t4_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    run_img1("t4r");

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Checksum good / bad on a one-word image
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      exp_q.push_back({32'h0, 32'h00000093});
      drive_byte(8'h01); drive_byte(8'h00); drive_byte(8'h00); drive_byte(8'h00);
      drive_byte(8'h93); drive_byte(8'h00); drive_byte(8'h00); drive_byte(8'h00);
      idle(1);
      check_eq("t6_wait_chk", 64'(done | error), 64'd0);
      drive_byte((pass == 0) ? 8'h92 : 8'h00);
      check_eq("t6_done", 64'(done), (pass == 0) ? 64'd1 : 64'd0);
      check_eq("t6_error", 64'(error), (pass == 0) ? 64'd0 : 64'd1);
      check_eq("t6_cpu_rst", 64'(cpu_rst), (pass == 0) ? 64'd0 : 64'd1);
    end
`endif

    // BASE_ADDR 0x100, three words at full rate
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_byte_b(img3[i]);
      if (i >= 4) begin
        if ((i % 4) == 3) begin
          check_eq("t5_we", 64'(imem_we_b), 64'd1);
          check_eq("t5_addr", 64'(imem_addr_b), 64'(32'h100 + 32'(4 * ((i - 7) / 4))));
          check_eq("t5_data", 64'(imem_wdata_b), 64'(img3_words[(i - 7) / 4]));
        end else begin
          check_eq("t5_we_idle", 64'(imem_we_b), 64'd0);
        end
      end
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    drive_byte_b(8'h21);
`else
    idle(1);
`endif
    check_eq("t5_done", 64'(done_b), 64'd1);
    check_eq("t5_cpu_rst", 64'(cpu_rst_b), 64'd0);
    check_eq("t5_addr_end", 64'(imem_addr_b), 64'h10C);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
